// File: rtl/gftt_nms_pkg.sv
// Shared definitions for the GFTT non-maximum-suppression block.
// Holds the frame state encoding, the eigen score width and the
// coordinate / keypoint counter widths used by gftt_nms and its line buffer.
package gftt_nms_pkg;

    localparam int SCORE_W  = 16;  // eigen score width
    localparam int X_W      = 10;  // column coordinate width
    localparam int Y_W      = 9;   // row coordinate width
    localparam int KP_CNT_W = 12;  // keypoint budget / counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gftt_state_t;

endpackage : gftt_nms_pkg

// File: rtl/gftt_nms_lbuf.sv
// Line buffer RAM for gftt_nms: simple dual-port, single clock, DEPTH words.
// Each word packs two image rows for one column: [2*SW-1:SW] = row y-2,
// [SW-1:0] = row y-1. Registered read; a read and write to the same address
// in one cycle returns the old contents.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address (column)
//   wdata  - packed {row y-2, row y-1} word to store
//   raddr  - read address (column)
//   rdata  - registered read data
module gftt_nms_lbuf #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule : gftt_nms_lbuf

// File: rtl/gftt_nms.sv
// GFTT non-maximum suppression over a raster stream of eigen scores.
// A 3x3 window is formed from two buffered rows plus the live stream; the
// centre pixel is emitted as a keypoint when it passes the threshold and is a
// local maximum (strict against earlier raster neighbours, non-strict against
// later ones so a flat plateau yields only its first pixel). Border pixels are
// never emitted and the per-frame keypoint budget is enforced.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   enb               - block enable; low forces idle
//   start             - one-cycle frame start pulse
//   wdt_m1, hgt_m1    - image width-1, height-1
//   thr               - minimum score
//   max_kp            - keypoint budget per frame
//   din, vin          - score stream and its valid
//   kp_vout           - keypoint valid pulse
//   kp_x, kp_y        - keypoint coordinates
//   kp_score          - keypoint score
//   kp_cnt            - keypoints emitted this frame
//   ovf               - sticky: a kept candidate was dropped for budget
//   done              - one-cycle end-of-frame pulse
module gftt_nms #(
    parameter int MAX_WDT = 1024,
    parameter int SCORE_W = gftt_nms_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               start,
    input  logic [9:0]         wdt_m1,
    input  logic [8:0]         hgt_m1,
    input  logic [SCORE_W-1:0] thr,
    input  logic [11:0]        max_kp,
    input  logic [SCORE_W-1:0] din,
    input  logic               vin,
    output logic               kp_vout,
    output logic [9:0]         kp_x,
    output logic [8:0]         kp_y,
    output logic [SCORE_W-1:0] kp_score,
    output logic [11:0]        kp_cnt,
    output logic               ovf,
    output logic               done
);

    import gftt_nms_pkg::*;

    localparam int AW = $clog2(MAX_WDT);

    gftt_state_t        state_reg;
    logic [X_W-1:0]     x_cnt_reg;
    logic [Y_W-1:0]     y_cnt_reg;
    logic [1:0]         drain_reg;
    logic               done_reg;

    logic               accept;

    // stage 1: pixel accepted, line buffer read in flight
    logic               s1_vld_reg;
    logic [X_W-1:0]     s1_x_reg;
    logic [Y_W-1:0]     s1_y_reg;
    logic [SCORE_W-1:0] s1_din_reg;

    // stage 2: window holds columns x-2..x, centre is (x-1, y-1)
    logic               s2_vld_reg;
    logic [X_W-1:0]     s2_x_reg;
    logic [Y_W-1:0]     s2_y_reg;

    logic [2*SCORE_W-1:0] lb_rdata;
    logic [2*SCORE_W-1:0] lb_wdata;
    logic [AW-1:0]        lb_raddr;
    logic [AW-1:0]        lb_waddr;

    logic [SCORE_W-1:0] win_reg [3][3];   // [row: 0=y-2 .. 2=y][col: 0=x-2 .. 2=x]
    logic [SCORE_W-1:0] col_new [3];
    logic [8:0]         ok;
    logic               keep;
    logic               cand_ok;

    logic               kp_vout_reg;
    logic [X_W-1:0]     kp_x_reg;
    logic [Y_W-1:0]     kp_y_reg;
    logic [SCORE_W-1:0] kp_score_reg;
    logic [KP_CNT_W-1:0] kp_cnt_reg;
    logic               ovf_reg;

    assign accept = enb && (state_reg == RUN) && vin;

    // ------------------------------------------------------------------
    // Frame FSM and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_cnt_reg <= '0;
            y_cnt_reg <= '0;
            drain_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!enb) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg <= RUN;
                            x_cnt_reg <= '0;
                            y_cnt_reg <= '0;
                        end
                    end
                    RUN: begin
                        if (vin) begin
                            if (x_cnt_reg == wdt_m1) begin
                                x_cnt_reg <= '0;
                                if (y_cnt_reg == hgt_m1) begin
                                    state_reg <= DONE;
                                    drain_reg <= '0;
                                end else begin
                                    y_cnt_reg <= y_cnt_reg + 1'b1;
                                end
                            end else begin
                                x_cnt_reg <= x_cnt_reg + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // Two cycles let the last candidate leave the
                        // pipeline; done then follows the final kp_vout.
                        if (drain_reg == 2'd2) begin
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            drain_reg <= drain_reg + 2'd1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: read column x with the incoming pixel; one cycle later
    // write back {old row y-1 -> new y-2, this pixel -> new y-1}.
    // ------------------------------------------------------------------
    assign lb_raddr = AW'(x_cnt_reg);
    assign lb_waddr = AW'(s1_x_reg);
    assign lb_wdata = {lb_rdata[SCORE_W-1:0], s1_din_reg};

    gftt_nms_lbuf #(
        .DEPTH (MAX_WDT),
        .AW    (AW),
        .DW    (2*SCORE_W)
    ) u_lbuf (
        .clk   (clk),
        .we    (s1_vld_reg),
        .waddr (lb_waddr),
        .wdata (lb_wdata),
        .raddr (lb_raddr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_reg <= 1'b0;
            s1_x_reg   <= '0;
            s1_y_reg   <= '0;
            s1_din_reg <= '0;
            s2_vld_reg <= 1'b0;
            s2_x_reg   <= '0;
            s2_y_reg   <= '0;
        end else begin
            s1_vld_reg <= accept;
            s2_vld_reg <= enb && s1_vld_reg;
            if (accept) begin
                s1_x_reg   <= x_cnt_reg;
                s1_y_reg   <= y_cnt_reg;
                s1_din_reg <= din;
            end
            if (s1_vld_reg) begin
                s2_x_reg <= s1_x_reg;
                s2_y_reg <= s1_y_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // 3x3 shift window
    // ------------------------------------------------------------------
    assign col_new[0] = lb_rdata[2*SCORE_W-1:SCORE_W];
    assign col_new[1] = lb_rdata[SCORE_W-1:0];
    assign col_new[2] = s1_din_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            always_ff @(posedge clk) begin
                if (rst) begin
                    win_reg[gi][0] <= '0;
                    win_reg[gi][1] <= '0;
                    win_reg[gi][2] <= '0;
                end else if (s1_vld_reg) begin
                    win_reg[gi][0] <= win_reg[gi][1];
                    win_reg[gi][1] <= win_reg[gi][2];
                    win_reg[gi][2] <= col_new[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Keep rule, indexed in raster order over the window (4 = centre).
    // Earlier neighbours must be strictly beaten, later ones only matched.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_keep
            if (gi < 4) begin : g_pre
                assign ok[gi] = win_reg[1][1] > win_reg[gi/3][gi%3];
            end else if (gi > 4) begin : g_post
                assign ok[gi] = win_reg[1][1] >= win_reg[gi/3][gi%3];
            end else begin : g_thr
                assign ok[gi] = win_reg[1][1] >= thr;
            end
        end
    endgenerate

    assign keep = &ok;

    // x >= 2 and y >= 2 place the centre off the top/left border; the
    // right/bottom border can never be a centre since x, y never exceed
    // wdt_m1, hgt_m1. Both also exclude frames narrower/shorter than 3.
    assign cand_ok = s2_vld_reg && (s2_x_reg >= X_W'(2)) && (s2_y_reg >= Y_W'(2));

    // ------------------------------------------------------------------
    // Keypoint output and budget
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_vout_reg  <= 1'b0;
            kp_x_reg     <= '0;
            kp_y_reg     <= '0;
            kp_score_reg <= '0;
            kp_cnt_reg   <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            kp_vout_reg <= 1'b0;
            if (enb) begin
                if (state_reg == IDLE && start) begin
                    kp_cnt_reg <= '0;
                    ovf_reg    <= 1'b0;
                end else if (cand_ok && keep) begin
                    if (kp_cnt_reg == max_kp) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        kp_vout_reg  <= 1'b1;
                        kp_x_reg     <= s2_x_reg - 1'b1;
                        kp_y_reg     <= s2_y_reg - 1'b1;
                        kp_score_reg <= win_reg[1][1];
                        kp_cnt_reg   <= kp_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign kp_vout  = kp_vout_reg;
    assign kp_x     = kp_x_reg;
    assign kp_y     = kp_y_reg;
    assign kp_score = kp_score_reg;
    assign kp_cnt   = kp_cnt_reg;
    assign ovf      = ovf_reg;
    assign done     = done_reg;

endmodule : gftt_nms

// File: doc/gftt_nms.md
GFTT_NMS -- requirements
Module: gftt_nms

Interface
REQ-001 The module SHALL have parameter MAX_WDT, default 1024, the line buffer depth in pixels.
REQ-002 The module SHALL have parameter SCORE_W, default 16, the eigen score width.
REQ-003 Port clk SHALL be an input of 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input of 1 bit: synchronous, active-high reset.
REQ-005 Port enb SHALL be an input of 1 bit: block enable; when low, the block is forced idle.
REQ-006 Port start SHALL be an input of 1 bit: one-cycle frame start pulse (gftt_start).
REQ-007 Port wdt_m1 SHALL be an input of 10 bits: image width minus 1.
REQ-008 Port hgt_m1 SHALL be an input of 9 bits: image height minus 1.
REQ-009 Port thr SHALL be an input of 16 bits: minimum score threshold.
REQ-010 Port max_kp SHALL be an input of 12 bits: keypoint budget per frame.
REQ-011 Port din SHALL be an input of 16 bits: eigen score stream from gftt_eig, in raster order.
REQ-012 Port vin SHALL be an input of 1 bit: din valid; there is no backpressure.
REQ-013 Port kp_vout SHALL be an output of 1 bit: keypoint valid.
REQ-014 Port kp_x SHALL be an output of 10 bits: keypoint column.
REQ-015 Port kp_y SHALL be an output of 9 bits: keypoint row.
REQ-016 Port kp_score SHALL be an output of 16 bits: keypoint score.
REQ-017 Port kp_cnt SHALL be an output of 12 bits: number of keypoints emitted in the current frame.
REQ-018 Port ovf SHALL be an output of 1 bit: sticky flag; budget exhausted while a further candidate passed.
REQ-019 Port done SHALL be an output of 1 bit: one-cycle pulse at frame end.

Function
REQ-020 The state machine SHALL have states IDLE, RUN and DONE.
REQ-021 IDLE SHALL go to RUN on start&enb; on entry, clear x/y counters, kp_cnt and ovf.
REQ-022 RUN SHALL go to DONE on the cycle when vin is high with x==wdt_m1 and y==hgt_m1.
REQ-023 DONE SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-024 The x counter SHALL increment on each vin in RUN and wrap to 0 after wdt_m1, incrementing y.
REQ-025 vin SHALL be ignored outside RUN.
REQ-026 A start while in RUN or DONE SHALL be ignored.
REQ-027 enb low in any state SHALL force IDLE, deassert kp_vout and done, and leave kp_cnt and ovf holding their values.
REQ-028 Two line buffers of MAX_WDT x 16 bits SHALL hold rows y-1 and y-2, and a 3x3 shift window SHALL be formed from them and din.
REQ-029 The candidate SHALL be the centre pixel (x-1, y-1), evaluated when pixel (x, y) arrives.
REQ-030 The candidate SHALL be evaluated only when 1<=x-1<=wdt_m1-1 and 1<=y-1<=hgt_m1-1; border pixels SHALL never be emitted.
REQ-031 Keep rule: the centre SHALL be kept iff centre>=thr, centre>neighbours preceding it in raster order (NW,N,NE,W), and centre>=neighbours following it (E,SW,S,SE).
REQ-032 All comparisons SHALL be unsigned 16-bit.
REQ-033 Because of the tie rule in REQ-031, a flat plateau SHALL emit exactly its first raster pixel.
REQ-034 A kept candidate SHALL produce kp_vout=1 exactly 2 clk after the vin of pixel (x, y), with kp_x=x-1, kp_y=y-1 and kp_score=centre.
REQ-035 kp_x, kp_y and kp_score SHALL be held between pulses.
REQ-036 kp_cnt SHALL increment with each kp_vout.
REQ-037 When kp_cnt==max_kp, further kept candidates SHALL be dropped, with no kp_vout, and ovf SHALL be set to 1.
REQ-038 max_kp=0 SHALL suppress all output.
REQ-039 Keypoints in flight SHALL still be emitted in the 2 cycles after the final pixel.
REQ-040 done SHALL be issued after the last kp_vout of the frame; the pipeline SHALL drain before DONE.
REQ-041 wdt_m1<2 or hgt_m1<2 SHALL produce a frame with zero keypoints and a normal done.

Reset
REQ-042 On rst, the state SHALL be IDLE.
REQ-043 On rst, kp_vout, done and ovf SHALL be 0.
REQ-044 On rst, kp_x, kp_y, kp_score and kp_cnt SHALL be 0.
REQ-045 On rst, the window registers SHALL be 0; line buffer contents SHALL be don't-care.
REQ-046 rst mid-frame SHALL abandon the frame with no done; the next start SHALL begin cleanly.

Structure
REQ-047 The shared gftt package SHALL hold the state encoding, SCORE_W and the coordinate widths (10/9 bits).
REQ-048 Sub-module gftt_nms_lbuf SHALL be a single-clock simple dual-port RAM, MAX_WDT x 32 bits, with read-before-write at the same address.
REQ-049 gftt_nms_lbuf SHALL store both line-buffer rows packed in one word.

Verification
REQ-050 8x6 frame, all 0 except (3,2)=500, thr=100 -> one kp_vout with x=3, y=2, score=500, 2 clk after pixel (4,3); kp_cnt=1; done=1.
REQ-051 8x6 frame, 2x2 plateau of 700 at (2..3,2..3) -> exactly one keypoint, at (2,2).
REQ-052 Peak 900 at (0,2) and at (7,4) on an 8x6 frame -> no keypoints.
REQ-053 Five isolated peaks of 300, max_kp=3 -> three keypoints, kp_cnt=3, ovf=1.
REQ-054 Peak of 50 with thr=100 -> none; same peak with thr=50 -> one keypoint.
REQ-055 Mid-frame enb low, or rst mid-frame, then a restart with a full frame -> no done for the aborted frame; second frame results match REQ-050.
